// File: rtl/pwm_pkg.sv
// pwm_pkg: shared definitions for the multi-channel PWM generator.
//   PWM_MAX_WIDTH    - largest supported counter/period/duty width
//   PWM_MAX_CHANNELS - largest supported channel count
//   pwm_dir_t        - counter direction (center-aligned mode)
package pwm_pkg;

    localparam int unsigned PWM_MAX_WIDTH    = 16;
    localparam int unsigned PWM_MAX_CHANNELS = 16;

    typedef enum logic {
        UP   = 1'b0,
        DOWN = 1'b1
    } pwm_dir_t;

endpackage

// File: rtl/pwm_channel.sv
// pwm_channel: one PWM output with double-buffered duty.
//   clk      in  rising-edge clock
//   reset_n  in  asynchronous active-low reset
//   enable   in  run; low forces the output low on the next edge
//   cfg_load in  capture duty into the pending register
//   apply    in  copy pending duty into the active register
//   duty     in  WIDTH-bit compare value
//   cnt      in  shared counter value
//   pwm_out  out registered output = enable && (cnt < active duty)
module pwm_channel
    import pwm_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             cfg_load,
    input  logic             apply,
    input  logic [WIDTH-1:0] duty,
    input  logic [WIDTH-1:0] cnt,
    output logic             pwm_out
);

    logic [WIDTH-1:0] duty_pend_q;
    logic [WIDTH-1:0] duty_act_q;
    logic             pwm_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            duty_pend_q <= '0;
            duty_act_q  <= '0;
            pwm_q       <= 1'b0;
        end else begin
            // Apply reads the old pending value when a load lands on the same edge.
            if (apply) begin
                duty_act_q <= duty_pend_q;
            end
            if (cfg_load) begin
                duty_pend_q <= duty;
            end
            pwm_q <= enable && (cnt < duty_act_q);
        end
    end

    assign pwm_out = pwm_q;

endmodule

// File: rtl/pwm_multi.sv
// pwm_multi: multi-channel PWM generator with one shared counter, so all
// channels are phase-aligned. Period and duty are double-buffered and only
// change at a period boundary (or continuously while idle).
// Optional center-aligned mode is built when PWM_CENTER_ALIGN_EN is defined.
//   clk         in  rising-edge clock
//   reset_n     in  asynchronous active-low reset
//   enable      in  run counter; low = idle
//   period      in  WIDTH-bit terminal count
//   duty        in  CHANNELS*WIDTH compare values, channel k at [k*WIDTH +: WIDTH]
//   cfg_load    in  capture period/duty/center into the pending set
//   center      in  center-aligned select (PWM_CENTER_ALIGN_EN only)
//   pwm_out     out CHANNELS registered PWM outputs
//   period_end  out one-cycle pulse on the first output cycle of each period
//   cfg_pending out pending set captured but not yet applied
module pwm_multi
    import pwm_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned CHANNELS = 4
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      enable,
    input  logic [WIDTH-1:0]          period,
    input  logic [CHANNELS*WIDTH-1:0] duty,
    input  logic                      cfg_load,
`ifdef PWM_CENTER_ALIGN_EN
    input  logic                      center,
`endif
    output logic [CHANNELS-1:0]       pwm_out,
    output logic                      period_end,
    output logic                      cfg_pending
);

    if (WIDTH < 2 || WIDTH > PWM_MAX_WIDTH) begin : g_bad_width
        $error("pwm_multi: WIDTH out of range");
    end
    if (CHANNELS < 1 || CHANNELS > PWM_MAX_CHANNELS) begin : g_bad_channels
        $error("pwm_multi: CHANNELS out of range");
    end

    logic [WIDTH-1:0] period_pend_q, period_act_q;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             cfg_pending_q, cfg_pending_d;
    logic             period_end_q;
    logic             wrap;
    logic             apply;
    logic             first_cycle;

`ifdef PWM_CENTER_ALIGN_EN
    logic     center_pend_q, center_act_q;
    pwm_dir_t dir_q, dir_d;
`endif

    always_comb begin
        wrap  = 1'b0;
        cnt_d = cnt_q;
`ifdef PWM_CENTER_ALIGN_EN
        dir_d = dir_q;
        if (!enable) begin
            cnt_d = '0;
            dir_d = UP;
        end else if (center_act_q) begin
            // Both ends are held for one extra cycle: P,P at the top, 0,0 across the wrap.
            if (dir_q == UP) begin
                if (cnt_q == period_act_q) begin
                    dir_d = DOWN;
                end else begin
                    cnt_d = cnt_q + WIDTH'(1);
                end
            end else begin
                if (cnt_q == '0) begin
                    wrap  = 1'b1;
                    dir_d = UP;
                end else begin
                    cnt_d = cnt_q - WIDTH'(1);
                end
            end
        end else begin
            dir_d = UP;
            if (cnt_q == period_act_q) begin
                wrap  = 1'b1;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + WIDTH'(1);
            end
        end
        // Down-count also passes 0; only the up-going 0 starts a period.
        first_cycle = (cnt_q == '0) && (dir_q == UP);
`else
        if (!enable) begin
            cnt_d = '0;
        end else if (cnt_q == period_act_q) begin
            wrap  = 1'b1;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + WIDTH'(1);
        end
        first_cycle = (cnt_q == '0);
`endif
        // Idle makes the active set transparent to the pending set.
        apply = !enable || wrap;

        cfg_pending_d = cfg_pending_q;
        if (cfg_load) begin
            cfg_pending_d = 1'b1;
        end else if (apply) begin
            cfg_pending_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            period_pend_q <= '0;
            period_act_q  <= '0;
            cnt_q         <= '0;
            cfg_pending_q <= 1'b0;
            period_end_q  <= 1'b0;
        end else begin
            if (apply) begin
                period_act_q <= period_pend_q;
            end
            if (cfg_load) begin
                period_pend_q <= period;
            end
            cnt_q         <= cnt_d;
            cfg_pending_q <= cfg_pending_d;
            period_end_q  <= enable && first_cycle;
        end
    end

`ifdef PWM_CENTER_ALIGN_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            center_pend_q <= 1'b0;
            center_act_q  <= 1'b0;
            dir_q         <= UP;
        end else begin
            if (apply) begin
                center_act_q <= center_pend_q;
            end
            if (cfg_load) begin
                center_pend_q <= center;
            end
            dir_q <= dir_d;
        end
    end
`endif

    for (genvar k = 0; k < int'(CHANNELS); k++) begin : g_ch
        pwm_channel #(
            .WIDTH (WIDTH)
        ) u_ch (
            .clk      (clk),
            .reset_n  (reset_n),
            .enable   (enable),
            .cfg_load (cfg_load),
            .apply    (apply),
            .duty     (duty[k*WIDTH +: WIDTH]),
            .cnt      (cnt_q),
            .pwm_out  (pwm_out[k])
        );
    end

    assign period_end  = period_end_q;
    assign cfg_pending = cfg_pending_q;

endmodule

// File: doc/pwm_multi.md
# pwm_multi

Parametrised multi-channel PWM generator: the successor to the single-channel 8-bit `pwm`. It adds configurable counter width, channel count and period. Period and per-channel duty are double-buffered, so new values take effect only at a period boundary and never glitch an output mid-period. One shared counter drives all channels, so all channel outputs are phase-aligned; it sits between the register/control logic and the pads or motor/LED drivers.

## Interface
- `WIDTH`, 8: counter, period and duty width in bits (2..16).
- `CHANNELS`, 4: number of independent PWM outputs (1..16).

- `clk`  in  1  rising-edge clock.
- `reset_n`  in  1  asynchronous, active-low reset; deassertion synchronous to `clk` is assumed.
- `enable`  in  1  run counter; low = idle.
- `period`  in  WIDTH  terminal count; edge-aligned period is `period`+1 cycles.
- `duty`  in  CHANNELS*WIDTH  per-channel compare value; channel k occupies bits [k*WIDTH +: WIDTH].
- `cfg_load`  in  1  one-cycle strobe that captures `period`/`duty` (and `center`) into pending registers.
- `center`  in  1  center-aligned mode select; present only with `PWM_CENTER_ALIGN_EN`.
- `pwm_out`  out  CHANNELS  registered PWM outputs.
- `period_end`  out  1  one-cycle pulse marking the first output cycle of each period.
- `cfg_pending`  out  1  pending values are captured but not yet applied.

## Operation
- Registers:
  - pending set: `period`, `duty`, `center`;
  - active set: the same three;
  - counter `cnt` (WIDTH bits);
  - direction bit `dir` (center mode only).
- `cfg_load` high: the pending set is overwritten and `cfg_pending`←1. A second `cfg_load` before the set is applied overwrites it; last write wins.
- Apply (active←pending, `cfg_pending`←0):
  - at the counter wrap edge when `enable`=1;
  - on every cycle when `enable`=0, so the active set is transparent while idle.
  - `cfg_load` in the same cycle as an apply: the apply uses the old pending set; the new values stay pending.
- Edge mode:
  - `cnt` counts 0..active period, then wraps to 0;
  - active period = 0 gives `cnt` fixed at 0 and a wrap every cycle.
- Compare rule, per channel: `pwm_out`[k] next = `enable` && (`cnt` < duty_k), an unsigned compare.
  - duty = 0: output constant low.
  - duty > period: output constant high.
  - Consequence: at period = 2^WIDTH−1 the maximum on-time is (2^WIDTH−1)/2^WIDTH; 100 % is not reachable.
- `enable`=0:
  - `cnt`←0 and `dir`←up;
  - `pwm_out` and `period_end` go low on the next edge.
  - On re-enable, the first period starts at `cnt`=0.

## Timing
- Reset values: `pwm_out`=0, `period_end`=0, `cfg_pending`=0, `cnt`=0, `dir`=up. Both register sets reset to 0 (period 0, duty 0, edge mode).
- Output latency:
  - `pwm_out` and `period_end` are registered from the current `cnt`, so each output lags `cnt` by one cycle;
  - `period_end` = registered (`enable` && `cnt`==0 && first cycle of the period).
- New duty or period is seen on `pwm_out` at the first `period_end` following the apply edge. The period in progress completes unchanged.
- A reset asserted mid-period clears all state immediately (asynchronous); pending values are lost.
- `cfg_load` while idle: the values apply on the next edge and show on `pwm_out` one cycle after `enable` rises.

## Configuration
- `PWM_CENTER_ALIGN_EN` defined:
  - the `center` port and the `dir` register exist;
  - with active center=1, `cnt` runs 0..P up, then P..0 down (P repeated, 0 repeated at the wrap);
  - period is 2(P+1) cycles and on-time is 2·min(duty, P+1) cycles, centered on `cnt`=0;
  - the wrap (and apply) happens at the down→up turn at 0.
- `PWM_CENTER_ALIGN_EN` undefined: the port and `dir` are absent and the block is edge-aligned only.

## Structure
- `pwm_pkg`:
  - limits `PWM_MAX_WIDTH`=16 and `PWM_MAX_CHANNELS`=16;
  - direction enum `pwm_dir_t` {UP, DOWN}.
- Sub-module `pwm_channel`, instantiated CHANNELS times, contains:
  - pending and active duty registers;
  - the compare;
  - the output flop.
- The top level owns the counter, the direction, the period registers and the apply logic.

## Test plan
- Reset (WIDTH=8, CHANNELS=4): hold `reset_n`=0 → all outputs 0; release with `enable`=0 → outputs stay 0.
- Basic output: load `period`=9, ch0 `duty`=5, then set `enable`=1 → ch0 high 5 cycles and low 5 cycles, repeating; `period_end` every 10 cycles, coincident with the ch0 rising edge.
- Extremes: ch1 `duty`=0 → constant low. ch2 `duty`=10 with `period`=9 → constant high. ch3 `duty`=255 with `period`=255 → low exactly 1 of 256 cycles.
- Mid-period update: `cfg_load` with ch0 `duty`=2 at `cnt`=3 → the current period keeps 5 high cycles; `cfg_pending`=1 until the wrap; the next period has 2 high cycles.
- Disable: drop `enable` at `cnt`=6 → `pwm_out`=0 next cycle and `cnt`=0. Re-enable → the first `period_end` arrives one cycle later, followed by a full 10-cycle period.
- Center mode (macro on): `period`=3, ch0 `duty`=1, `center`=1 → `cnt` sequence 0,1,2,3,3,2,1,0 (8-cycle period); ch0 high 2 contiguous cycles across the wrap.
